// File: rtl/data_memory_ls_if.sv
// Request/response bus between a load/store unit (master) and data_memory_ls (slave).
// One outstanding transaction; each side has its own valid/ready handshake.
interface data_memory_ls_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] ReadData;
   logic        rsp_error;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, Address, WriteData, rsp_ready,
      input  req_ready, rsp_valid, ReadData, rsp_error
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, Address, WriteData, rsp_ready,
      output req_ready, rsp_valid, ReadData, rsp_error
   );
endinterface

// File: rtl/data_memory_ls.sv
// Byte/half/word load-store data memory with configurable base, depth and read latency.
// Misaligned, out-of-range and reserved-size requests are answered with rsp_error instead of data.
module data_memory_ls #(
   parameter int unsigned MEM_WORDS    = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned READ_LATENCY = 1
) (
   input logic              clk,
   input logic              reset,
   data_memory_ls_if.slave  bus
);

   localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
   localparam logic [1:0]  CNT_INIT = 2'(READ_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem [MEM_WORDS];

   logic [29:0]      offset_words;
   logic [IDX_W-1:0] word_idx;
   logic             below_base;
   logic             out_of_range;
   logic             bad_size;
   logic             bad_align;
   logic             req_err;
   logic             accept;
   logic             do_store;
   logic [3:0]       byte_en;
   logic [31:0]      store_data;
   logic [31:0]      load_word;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [31:0]      load_ext;

   // BASE_ADDR is word aligned, so the word offset can be formed from bits [31:2] alone.
   always_comb begin
      offset_words = bus.Address[31:2] - BASE_ADDR[31:2];
      word_idx     = offset_words[IDX_W-1:0];
      below_base   = bus.Address < BASE_ADDR;
      out_of_range = offset_words >= 30'(MEM_WORDS);
      bad_size     = bus.req_size == 2'b11;
      bad_align    = ((bus.req_size == 2'b01) && bus.Address[0]) ||
                     ((bus.req_size == 2'b10) && (bus.Address[1:0] != 2'b00));
      req_err      = bad_size || bad_align || below_base || out_of_range;
      accept       = (state_q == IDLE) && bus.req_valid && !reset;
      do_store     = accept && bus.req_write && !req_err;
   end

   always_comb begin
      byte_en    = 4'b1111;
      store_data = bus.WriteData;
      case (bus.req_size)
         2'b00: begin
            byte_en    = 4'b0001 << bus.Address[1:0];
            store_data = {4{bus.WriteData[7:0]}};
         end
         2'b01: begin
            byte_en    = bus.Address[1] ? 4'b1100 : 4'b0011;
            store_data = {2{bus.WriteData[15:0]}};
         end
         default: begin
            byte_en    = 4'b1111;
            store_data = bus.WriteData;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_store) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
            end
         end
      end
   end

   // The word is read at the accept edge and extended immediately, so later stores cannot disturb it.
   always_comb begin
      load_word = mem[word_idx];
      byte_sel  = load_word[{bus.Address[1:0], 3'b000} +: 8];
      half_sel  = bus.Address[1] ? load_word[31:16] : load_word[15:0];
      case (bus.req_size)
         2'b00:   load_ext = bus.req_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = bus.req_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_ext = load_word;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               rdata_d = (!bus.req_write && !req_err) ? load_ext : 32'd0;
               err_d   = req_err;
               if (bus.req_write || req_err || (READ_LATENCY == 1)) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
               rdata_d = 32'd0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE) && !reset;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.ReadData  = rdata_q;
   assign bus.rsp_error = err_q;

endmodule

// File: tb/tb_data_memory_ls.sv
// Directed bench for data_memory_ls: three instances (latency 1, 3 and 4 with a non-zero base)
// share one stimulus driver; sel routes requests to one instance and muxes its outputs back.
module tb_data_memory_ls;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int          sel;
   logic        req_valid, req_write, req_unsigned, rsp_ready;
   logic [1:0]  req_size;
   logic [31:0] addr, wdata;
   logic        req_ready_m, rsp_valid_m, rsp_err_m;
   logic [31:0] rdata_m;

   int total = 0;
   int bad   = 0;

   data_memory_ls_if busA();
   data_memory_ls_if busB();
   data_memory_ls_if busC();

   assign busA.req_valid    = req_valid && (sel == 0);
   assign busA.rsp_ready    = rsp_ready && (sel == 0);
   assign busA.req_write    = req_write;
   assign busA.req_size     = req_size;
   assign busA.req_unsigned = req_unsigned;
   assign busA.Address      = addr;
   assign busA.WriteData    = wdata;

   assign busB.req_valid    = req_valid && (sel == 1);
   assign busB.rsp_ready    = rsp_ready && (sel == 1);
   assign busB.req_write    = req_write;
   assign busB.req_size     = req_size;
   assign busB.req_unsigned = req_unsigned;
   assign busB.Address      = addr;
   assign busB.WriteData    = wdata;

   assign busC.req_valid    = req_valid && (sel == 2);
   assign busC.rsp_ready    = rsp_ready && (sel == 2);
   assign busC.req_write    = req_write;
   assign busC.req_size     = req_size;
   assign busC.req_unsigned = req_unsigned;
   assign busC.Address      = addr;
   assign busC.WriteData    = wdata;

   always_comb begin
      case (sel)
         1: begin
            req_ready_m = busB.req_ready; rsp_valid_m = busB.rsp_valid;
            rdata_m     = busB.ReadData;  rsp_err_m   = busB.rsp_error;
         end
         2: begin
            req_ready_m = busC.req_ready; rsp_valid_m = busC.rsp_valid;
            rdata_m     = busC.ReadData;  rsp_err_m   = busC.rsp_error;
         end
         default: begin
            req_ready_m = busA.req_ready; rsp_valid_m = busA.rsp_valid;
            rdata_m     = busA.ReadData;  rsp_err_m   = busA.rsp_error;
         end
      endcase
   end

   data_memory_ls #(.MEM_WORDS(64), .BASE_ADDR(32'h0000_0000), .READ_LATENCY(1))
      dutA (.clk(clk), .reset(reset), .bus(busA));
   data_memory_ls #(.MEM_WORDS(64), .BASE_ADDR(32'h0000_0000), .READ_LATENCY(3))
      dutB (.clk(clk), .reset(reset), .bus(busB));
   data_memory_ls #(.MEM_WORDS(64), .BASE_ADDR(32'h0000_1000), .READ_LATENCY(4))
      dutC (.clk(clk), .reset(reset), .bus(busC));

   typedef struct {
      string       name;
      int          sel;
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expData;
      logic        expErr;
      int          expLat;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input string n, input int s, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee, input int el);
      vec_t v;
      v.name = n; v.sel = s; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = a; v.wdata = wd;
      v.expData = ed; v.expErr = ee; v.expLat = el;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One complete transaction; called at posedge+1 and returns at posedge+1 after the response handshake.
   task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er, output int lat);
      int guard;
      req_write = wr; req_size = sz; req_unsigned = uns; addr = a; wdata = wd;
      req_valid = 1'b1; rsp_ready = 1'b1;
      guard = 0;
      while (!req_ready_m && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid_m && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = rdata_m;
      er = rsp_err_m;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   function automatic logic [31:0] expWord(input int i);
      return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
   endfunction

   task automatic backToBack(input int s, input int rl, input logic [31:0] base);
      logic [31:0] rd;
      logic        er;
      int          lat, cyc, acc, rsp, lastAcc;
      logic        willAccept;
      sel = s;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 2'b10, 1'b0, base + 32'(i * 4), expWord(i), rd, er, lat);
      end
      cyc = 0; acc = 0; rsp = 0; lastAcc = -1;
      req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; addr = base;
      req_valid = 1'b1; rsp_ready = 1'b1;
      while (rsp < 16 && cyc < 400) begin
         willAccept = req_ready_m && (acc < 16);
         if (rsp_valid_m) begin
            checkOutput($sformatf("b2b%0d.data%0d", s, rsp), rdata_m, expWord(rsp));
            rsp++;
         end
         if (willAccept) begin
            if (lastAcc >= 0) begin
               checkOutput($sformatf("b2b%0d.spacing%0d", s, acc), 32'(cyc - lastAcc), 32'(rl + 1));
            end
            lastAcc = cyc;
            acc++;
         end
         @(posedge clk); #1;
         cyc++;
         if (willAccept) begin
            if (acc < 16) addr = base + 32'(acc * 4);
            else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0; rsp_ready = 1'b0;
      checkOutput($sformatf("b2b%0d.count", s), 32'(rsp), 32'd16);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      sel = 0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      addr = 32'd0; wdata = 32'd0; rsp_ready = 1'b0;

      // Reset state, then ready the cycle after release on every instance.
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst.reqReady", 32'(req_ready_m), 32'd0);
      checkOutput("rst.rspValid", 32'(rsp_valid_m), 32'd0);
      checkOutput("rst.readData", rdata_m, 32'd0);
      checkOutput("rst.rspError", 32'(rsp_err_m), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #0;
         checkOutput($sformatf("rst.readyAfter%0d", s), 32'(req_ready_m), 32'd1);
      end

      addVec("stW00",     0, 1, 2'b10, 0, 32'h00, 32'h0BAD_F00D, 32'h0,          0, 1);
      addVec("stW10",     0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 32'h0,          0, 1);
      addVec("ldW10",     0, 0, 2'b10, 0, 32'h10, 32'h0,         32'hDEAD_BEEF,  0, 1);
      addVec("stB13",     0, 1, 2'b00, 0, 32'h13, 32'h1234_565A, 32'h0,          0, 1);
      addVec("ldW10b",    0, 0, 2'b10, 0, 32'h10, 32'h0,         32'h5AAD_BEEF,  0, 1);
      addVec("ldBs13",    0, 0, 2'b00, 0, 32'h13, 32'h0,         32'h0000_005A,  0, 1);
      addVec("ldBs12",    0, 0, 2'b00, 0, 32'h12, 32'h0,         32'hFFFF_FFAD,  0, 1);
      addVec("ldBu12",    0, 0, 2'b00, 1, 32'h12, 32'h0,         32'h0000_00AD,  0, 1);
      addVec("ldHs12",    0, 0, 2'b01, 0, 32'h12, 32'h0,         32'h0000_5AAD,  0, 1);
      addVec("ldHs10",    0, 0, 2'b01, 0, 32'h10, 32'h0,         32'hFFFF_BEEF,  0, 1);
      addVec("ldHu10",    0, 0, 2'b01, 1, 32'h10, 32'h0,         32'h0000_BEEF,  0, 1);
      addVec("ldWu10",    0, 0, 2'b10, 1, 32'h10, 32'h0,         32'h5AAD_BEEF,  0, 1);
      addVec("stW14",     0, 1, 2'b10, 0, 32'h14, 32'h1122_3344, 32'h0,          0, 1);
      addVec("stH16",     0, 1, 2'b01, 0, 32'h16, 32'hFFFF_AABB, 32'h0,          0, 1);
      addVec("ldW14",     0, 0, 2'b10, 0, 32'h14, 32'h0,         32'hAABB_3344,  0, 1);
      addVec("ldBs15",    0, 0, 2'b00, 0, 32'h15, 32'h0,         32'h0000_0033,  0, 1);
      addVec("ldBs17",    0, 0, 2'b00, 0, 32'h17, 32'h0,         32'hFFFF_FFAA,  0, 1);
      addVec("errStH11",  0, 1, 2'b01, 0, 32'h11, 32'hFFFF_0000, 32'h0,          1, 1);
      addVec("errLdW12",  0, 0, 2'b10, 0, 32'h12, 32'h0,         32'h0,          1, 1);
      addVec("errLdSz3",  0, 0, 2'b11, 0, 32'h10, 32'h0,         32'h0,          1, 1);
      addVec("errStSz3",  0, 1, 2'b11, 0, 32'h10, 32'h0,         32'h0,          1, 1);
      addVec("errLdOob",  0, 0, 2'b10, 0, 32'h100, 32'h0,        32'h0,          1, 1);
      addVec("errStOob",  0, 1, 2'b10, 0, 32'h100, 32'h9999_9999, 32'h0,         1, 1);
      addVec("ldW10c",    0, 0, 2'b10, 0, 32'h10, 32'h0,         32'h5AAD_BEEF,  0, 1);
      addVec("ldW00",     0, 0, 2'b10, 0, 32'h00, 32'h0,         32'h0BAD_F00D,  0, 1);
      addVec("stWfc",     0, 1, 2'b10, 0, 32'hFC, 32'hCAFE_F00D, 32'h0,          0, 1);
      addVec("ldWfc",     0, 0, 2'b10, 0, 32'hFC, 32'h0,         32'hCAFE_F00D,  0, 1);
      addVec("stW18",     0, 1, 2'b10, 0, 32'h18, 32'h1357_2468, 32'h0,          0, 1);
      addVec("B.stW20",   1, 1, 2'b10, 0, 32'h20, 32'h8765_4321, 32'h0,          0, 1);
      addVec("B.ldHu22",  1, 0, 2'b01, 1, 32'h22, 32'h0,         32'h0000_8765,  0, 3);
      addVec("B.ldHs22",  1, 0, 2'b01, 0, 32'h22, 32'h0,         32'hFFFF_8765,  0, 3);
      addVec("B.ldBs20",  1, 0, 2'b00, 0, 32'h20, 32'h0,         32'h0000_0021,  0, 3);
      addVec("B.errW21",  1, 0, 2'b10, 0, 32'h21, 32'h0,         32'h0,          1, 1);
      addVec("C.errBelow",2, 0, 2'b10, 0, 32'h0FFC, 32'h0,       32'h0,          1, 1);
      addVec("C.stW1000", 2, 1, 2'b10, 0, 32'h1000, 32'h0102_0304, 32'h0,        0, 1);
      addVec("C.ldW1000", 2, 0, 2'b10, 0, 32'h1000, 32'h0,       32'h0102_0304,  0, 4);
      addVec("C.ldBu1003",2, 0, 2'b00, 1, 32'h1003, 32'h0,       32'h0000_0001,  0, 4);
      addVec("C.errAbove",2, 0, 2'b10, 0, 32'h1100, 32'h0,       32'h0,          1, 1);

      foreach (vecs[i]) begin
         sel = vecs[i].sel;
         applyStimulus(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, lat);
         checkOutput({vecs[i].name, ".data"}, rd, vecs[i].expData);
         checkOutput({vecs[i].name, ".err"}, 32'(er), 32'(vecs[i].expErr));
         checkOutput({vecs[i].name, ".lat"}, 32'(lat), 32'(vecs[i].expLat));
      end

      // A store presented while reset is high must be neither accepted nor written.
      sel = 0;
      reset = 1'b1;
      req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; addr = 32'h18; wdata = 32'hBAD0_BAD0;
      req_valid = 1'b1; rsp_ready = 1'b1;
      #0;
      checkOutput("rstStore.reqReady", 32'(req_ready_m), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      #0;
      checkOutput("rstStore.rspValid", 32'(rsp_valid_m), 32'd0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, rd, er, lat);
      checkOutput("rstStore.data", rd, 32'h1357_2468);

      // Latency-3 load with response backpressure held for four cycles.
      sel = 1;
      req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; addr = 32'h20;
      req_valid = 1'b1; rsp_ready = 1'b0;
      #0;
      checkOutput("bp.readyBefore", 32'(req_ready_m), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 1; i < 3; i++) begin
         checkOutput($sformatf("bp.noRsp%0d", i), 32'(rsp_valid_m), 32'd0);
         checkOutput($sformatf("bp.busy%0d", i), 32'(req_ready_m), 32'd0);
         @(posedge clk); #1;
      end
      checkOutput("bp.rspRise", 32'(rsp_valid_m), 32'd1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("bp.hold%0d.valid", i), 32'(rsp_valid_m), 32'd1);
         checkOutput($sformatf("bp.hold%0d.data", i), rdata_m, 32'h8765_4321);
         checkOutput($sformatf("bp.hold%0d.err", i), 32'(rsp_err_m), 32'd0);
         checkOutput($sformatf("bp.hold%0d.ready", i), 32'(req_ready_m), 32'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checkOutput("bp.readyAfter", 32'(req_ready_m), 32'd1);
      checkOutput("bp.validAfter", 32'(rsp_valid_m), 32'd0);

      // Reset two cycles into a latency-4 load discards it.
      sel = 2;
      req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; addr = 32'h1000;
      req_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("rstWait.validInReset", 32'(rsp_valid_m), 32'd0);
      checkOutput("rstWait.readyInReset", 32'(req_ready_m), 32'd0);
      checkOutput("rstWait.data", rdata_m, 32'd0);
      checkOutput("rstWait.err", 32'(rsp_err_m), 32'd0);
      reset = 1'b0;
      #0;
      checkOutput("rstWait.readyAfter", 32'(req_ready_m), 32'd1);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("rstWait.noRsp%0d", i), 32'(rsp_valid_m), 32'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b0;
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, rd, er, lat);
      checkOutput("rstWait.reload.data", rd, 32'h0102_0304);
      checkOutput("rstWait.reload.lat", 32'(lat), 32'd4);

      backToBack(0, 1, 32'h40);
      backToBack(1, 3, 32'h40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
